// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding control for the 5-stage pipeline.
// Shadows Ex/Mem destinations, selects Ex operands, stalls, flushes.
module pipe_hazard_ctrl #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Id_Rs,
  input  logic [4:0] Id_Rt,
  input  logic [4:0] Id_Rw,
  input  logic       Id_UsesRs,
  input  logic       Id_UsesRt,
  input  logic       Id_RegWrite,
  input  logic       Id_MemRead,
  input  logic       Id_MulDivStart,
  input  logic       Id_UsesHiLo,
  input  logic       Ex_BranchTaken,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       Pc_Hold,
  output logic       Ex_Bubble,
  output logic       If_Flush,
  output logic       MulDiv_Busy
);

  // The Wr stage has no consumer here: its select code is implied
  // by a Mem-stage match at the edge the producer leaves Mem.
  logic [4:0]       ex_rw;
  logic             ex_rwe;
  logic             ex_mr;
  logic [4:0]       mem_rw;
  logic             mem_rwe;
  logic [CNT_W-1:0] cnt;

  logic       ex_hit_rs, ex_hit_rt;
  logic       mem_hit_rs, mem_hit_rt;
  logic       load_use, hilo, busy;
  logic       stall, bubble;
  logic [1:0] sel_a, sel_b;

  function automatic logic hit(
    input logic [4:0] x,
    input logic       we,
    input logic [4:0] rw
  );
    return we && (rw != 5'd0) && (rw == x);
  endfunction

  // Producer matches, hazard detection and stall/flush decisions
  always_comb begin
    ex_hit_rs  = Id_UsesRs && hit(Id_Rs, ex_rwe, ex_rw);
    ex_hit_rt  = Id_UsesRt && hit(Id_Rt, ex_rwe, ex_rw);
    mem_hit_rs = Id_UsesRs && hit(Id_Rs, mem_rwe, mem_rw);
    mem_hit_rt = Id_UsesRt && hit(Id_Rt, mem_rwe, mem_rw);
    busy       = (cnt != '0);
    load_use   = ex_mr && ex_rwe && (ex_hit_rs || ex_hit_rt);
    hilo       = busy && (Id_UsesHiLo || Id_MulDivStart);
    stall      = (load_use || hilo) && !Ex_BranchTaken;
    bubble     = stall || Ex_BranchTaken;
  end

  // Operand selects: youngest producer (Ex) beats Mem
  always_comb begin
    sel_a = 2'b00;
    sel_b = 2'b00;
    priority case (1'b1)
      ex_hit_rs:  sel_a = 2'b01;
      mem_hit_rs: sel_a = 2'b10;
      default:    sel_a = 2'b00;
    endcase
    priority case (1'b1)
      ex_hit_rt:  sel_b = 2'b01;
      mem_hit_rt: sel_b = 2'b10;
      default:    sel_b = 2'b00;
    endcase
  end

  // Status outputs forced quiet while reset is held
  always_comb begin
    Pc_Hold     = rst_n && stall;
    Ex_Bubble   = rst_n && bubble;
    If_Flush    = rst_n && Ex_BranchTaken;
    MulDiv_Busy = busy;
  end

  // Ex shadow and registered selects; bubble inserts a no-op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rw   <= '0;
      ex_rwe  <= 1'b0;
      ex_mr   <= 1'b0;
      ALUSrcA <= 2'b00;
      ALUSrcB <= 2'b00;
    end else if (bubble) begin
      ex_rw   <= '0;
      ex_rwe  <= 1'b0;
      ex_mr   <= 1'b0;
      ALUSrcA <= 2'b00;
      ALUSrcB <= 2'b00;
    end else begin
      ex_rw   <= Id_Rw;
      ex_rwe  <= Id_RegWrite;
      ex_mr   <= Id_MemRead;
      ALUSrcA <= sel_a;
      ALUSrcB <= sel_b;
    end
  end

  // Mem shadow always advances; nothing past Ex is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rw  <= '0;
      mem_rwe <= 1'b0;
    end else begin
      mem_rw  <= ex_rw;
      mem_rwe <= ex_rwe;
    end
  end

  // Mult/div busy counter: load on issue, count down otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (Id_MulDivStart && !bubble) begin
      cnt <= CNT_W'(MULDIV_LAT);
    end else if (busy) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed program snippets plus
// random traffic against an instruction-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Id_Rs, Id_Rt, Id_Rw;
  logic       Id_UsesRs, Id_UsesRt, Id_RegWrite, Id_MemRead;
  logic       Id_MulDivStart, Id_UsesHiLo, Ex_BranchTaken;
  logic [1:0] ALUSrcA, ALUSrcB;
  logic       Pc_Hold, Ex_Bubble, If_Flush, MulDiv_Busy;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .Id_Rs(Id_Rs), .Id_Rt(Id_Rt), .Id_Rw(Id_Rw),
    .Id_UsesRs(Id_UsesRs), .Id_UsesRt(Id_UsesRt),
    .Id_RegWrite(Id_RegWrite), .Id_MemRead(Id_MemRead),
    .Id_MulDivStart(Id_MulDivStart), .Id_UsesHiLo(Id_UsesHiLo),
    .Ex_BranchTaken(Ex_BranchTaken),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .Pc_Hold(Pc_Hold), .Ex_Bubble(Ex_Bubble),
    .If_Flush(If_Flush), .MulDiv_Busy(MulDiv_Busy)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the instructions occupying Ex and Mem
  typedef struct {
    logic [4:0] rw;
    logic       we;
    logic       ld;
  } ins_t;

  ins_t       m_ex, m_mem;
  logic [1:0] e_a, e_b;
  bit         v_a, v_b;
  longint     cyc = 0;
  longint     busy_until = 0;
  logic [1:0] o_a, o_b;
  logic       o_hold, o_bub, o_flush, o_busy;

  function automatic bit writes(input logic [4:0] x, input ins_t s);
    return s.we && s.rw != 0 && s.rw == x;
  endfunction

  function automatic logic [1:0] src(input bit uses, input logic [4:0] x);
    if (!uses) return 2'b00;
    if (writes(x, m_ex)) return 2'b01;
    if (writes(x, m_mem)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ex = '{default: '0};
    m_mem = '{default: '0};
    e_a = 2'b00; e_b = 2'b00;
    v_a = 1; v_b = 1;
    busy_until = 0;
  endtask

  task automatic step(input logic [4:0] rs, rt, rw,
                      input bit urs, urt, we, ld, mds, uhl, br);
    bit busy, lu, hl, st;
    ins_t nx;
    @(negedge clk);
    Id_Rs = rs; Id_Rt = rt; Id_Rw = rw;
    Id_UsesRs = urs; Id_UsesRt = urt;
    Id_RegWrite = we; Id_MemRead = ld;
    Id_MulDivStart = mds; Id_UsesHiLo = uhl;
    Ex_BranchTaken = br;
    #1;
    o_a = ALUSrcA; o_b = ALUSrcB;
    o_hold = Pc_Hold; o_bub = Ex_Bubble;
    o_flush = If_Flush; o_busy = MulDiv_Busy;
    busy = cyc < busy_until;
    lu = m_ex.ld && ((urs && writes(rs, m_ex)) ||
                     (urt && writes(rt, m_ex)));
    hl = busy && (uhl || mds);
    st = (lu || hl) && !br;
    chk("hold", o_hold, st);
    chk("bubble", o_bub, st || br);
    chk("flush", o_flush, br);
    chk("busy", o_busy, busy);
    if (v_a) chk("srcA", o_a, e_a);
    if (v_b) chk("srcB", o_b, e_b);
    @(posedge clk);
    if (st || br) begin
      nx = '{default: '0};
      e_a = 2'b00; e_b = 2'b00; v_a = 1; v_b = 1;
    end else begin
      nx = '{rw: rw, we: we, ld: ld};
      e_a = src(urs, rs); e_b = src(urt, rt);
      v_a = urs; v_b = urt;
      if (mds) busy_until = cyc + 1 + LAT;
    end
    m_mem = m_ex;
    m_ex = nx;
    cyc++;
  endtask

  task automatic alu(input logic [4:0] rd, rs, rt, input bit br = 0);
    step(rs, rt, rd, 1, 1, 1, 0, 0, 0, br);
  endtask

  task automatic lw(input logic [4:0] rd, base);
    step(base, 5'd0, rd, 1, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic nop();
    step(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mult(input logic [4:0] rs, rt);
    step(rs, rt, 5'd0, 1, 1, 0, 0, 1, 0, 0);
  endtask

  task automatic mfhi(input logic [4:0] rd);
    step(5'd0, 5'd0, rd, 0, 0, 1, 0, 0, 1, 0);
  endtask

  initial begin
    int n;
    Id_Rs = 0; Id_Rt = 0; Id_Rw = 0;
    Id_UsesRs = 0; Id_UsesRt = 0; Id_RegWrite = 0;
    Id_MemRead = 0; Id_MulDivStart = 0; Id_UsesHiLo = 0;
    Ex_BranchTaken = 1;
    rst_n = 0;
    model_reset();
    #12;
    chk("rst_flush", If_Flush, 0);
    chk("rst_hold", Pc_Hold, 0);
    chk("rst_bubble", Ex_Bubble, 0);
    chk("rst_busy", MulDiv_Busy, 0);
    chk("rst_srcA", ALUSrcA, 0);
    chk("rst_srcB", ALUSrcB, 0);
    Ex_BranchTaken = 0;
    @(negedge clk);
    rst_n = 1;

    // lw $2; add $3,$2,$4: one bubble, then Wr forwarding
    lw(2, 1);
    alu(3, 2, 4);
    chk("lu_hold", o_hold, 1);
    chk("lu_bub", o_bub, 1);
    alu(3, 2, 4);
    chk("lu_once", o_hold, 0);
    nop();
    chk("lu_fwdA", o_a, 2'b10);

    // add $2; sub $5,$2,$2: Mem forwarding on both sides
    alu(2, 1, 1);
    alu(5, 2, 2);
    chk("ex_nostall", o_hold, 0);
    nop();
    chk("ex_fwdA", o_a, 2'b01);
    chk("ex_fwdB", o_b, 2'b01);

    // add $2; nop; or $6,$7,$2: Wr forwarding on B only
    alu(2, 1, 1);
    nop();
    alu(6, 7, 2);
    nop();
    chk("wr_fwdA", o_a, 2'b00);
    chk("wr_fwdB", o_b, 2'b10);

    // $0 is never forwarded
    alu(0, 1, 1);
    alu(8, 0, 0);
    nop();
    chk("r0_A", o_a, 2'b00);
    chk("r0_B", o_b, 2'b00);

    // Youngest producer wins
    alu(9, 1, 1);
    alu(9, 1, 1);
    alu(10, 9, 9);
    nop();
    chk("young_A", o_a, 2'b01);

    // mult then mfhi: held exactly LAT cycles
    mult(1, 2);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      mfhi(11);
      if (!o_hold) break;
      n++;
    end
    chk("hilo_len", n, LAT);

    // Taken branch beats a load-use stall
    lw(2, 1);
    alu(3, 2, 4, 1);
    chk("br_hold", o_hold, 0);
    chk("br_flush", o_flush, 1);
    chk("br_bub", o_bub, 1);
    nop();
    chk("br_srcA", o_a, 2'b00);
    chk("br_srcB", o_b, 2'b00);
    chk("br_nostall", o_hold, 0);

    // Reset in the middle of a mult stall
    alu(2, 1, 1);
    mult(1, 2);
    mfhi(11);
    chk("mid_hold", o_hold, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("arst_busy", MulDiv_Busy, 0);
    chk("arst_hold", Pc_Hold, 0);
    chk("arst_srcA", ALUSrcA, 0);
    chk("arst_srcB", ALUSrcB, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    mfhi(11);
    chk("arst_nostall", o_hold, 0);

    // Random traffic on a small register set
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rs, rt, rw;
      bit ld, mds, uhl, br;
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rw = 5'($urandom_range(0, 3));
      ld = ($urandom_range(0, 3) == 0);
      mds = ($urandom_range(0, 15) == 0);
      uhl = ($urandom_range(0, 7) == 0);
      br = ($urandom_range(0, 9) == 0);
      step(rs, rt, rw, 1'($urandom), 1'($urandom),
           1'($urandom), ld, mds, uhl, br);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
